dmem_ctrl: RTL and testbench

- MEM-stage data-memory responder for the RV64 pipeline: the memory-side endpoint of the memreadM/memwriteM/RW_typeM request produced by pipeline control.
- Converts one load/store per instruction into a single-beat, 64-bit, byte-enabled bus transaction with wait states.
- Stalls the pipeline until the access completes, then returns load data sign- or zero-extended to 64 bits.
- Includes a bus-timeout watchdog.

---
 rtl/dmem_ctrl_if.sv | 36 +++
 rtl/dmem_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - single-beat 64-bit data bus between dmem_ctrl and memory
//
// Purpose: groups the byte-enabled data-memory bus so the controller and the
// memory model share one bundle.
// Signals:
//   bus_req    controller -> memory  request, held until bus_ready
//   bus_we     controller -> memory  1 = write
//   bus_addr   controller -> memory  doubleword-aligned address
//   bus_be     controller -> memory  byte enables
//   bus_wdata  controller -> memory  store data in byte lanes
//   bus_err    controller -> memory  one-cycle timeout pulse
//   bus_rdata  memory -> controller  read data, valid with bus_ready
//   bus_ready  memory -> controller  completes the beat
// Modports: master (controller side), slave (memory side).
interface dmem_ctrl_if #(
  parameter int ADDR_W = 64
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_be;
  logic [63:0]       bus_wdata;
  logic              bus_err;
  logic [63:0]       bus_rdata;
  logic              bus_ready;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - MEM-stage data-memory responder with wait states and timeout
//
// Purpose: turns one load/store per instruction into a single-beat byte-enabled
// bus transaction, stalls the pipeline until it completes, and returns load
// data sign/zero-extended to 64 bits. A watchdog forces completion after
// TIMEOUT cycles in WAIT.
// Optional macro: DMEM_MISALIGN_TRAP_EN adds output misalignM; misaligned
// requests then skip the bus and complete with misalignM=1. Without it,
// misaligned offsets are force-aligned to the access size.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   memreadM, memwriteM  load / store request from MEM stage
//   RW_typeM             size/sign: B,H,W,D,BU,HU,WU, 111 treated as D
//   addrM, wdataM        byte address, right-justified store data
//   rdataM, rvalidM      extended load data, one-cycle completion strobe
//   stallM               holds IF..MEM while an access is outstanding
//   misalignM            (optional) misaligned-access flag with rvalidM
//   bus                  dmem_ctrl_if master modport
module dmem_ctrl #(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memreadM,
  input  logic              memwriteM,
  input  logic [2:0]        RW_typeM,
  input  logic [ADDR_W-1:0] addrM,
  input  logic [63:0]       wdataM,
  output logic [63:0]       rdataM,
  output logic              rvalidM,
  output logic              stallM,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic              misalignM,
`endif
  dmem_ctrl_if.master       bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Last counter value before the watchdog fires: WAIT lasts at most TIMEOUT cycles.
  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  type_q;
  logic [2:0]  off_q;
  logic        load_q;

  logic        req;
  logic [2:0]  eoff;
  logic [7:0]  be_base;
  logic [63:0] shifted;

  // Offset bits below the access size are dropped (H: o&6, W: o&4, D: 0).
  function automatic logic [2:0] eff_off(input logic [2:0] t, input logic [2:0] o);
    case (t[1:0])
      2'b00:   return o;
      2'b01:   return {o[2:1], 1'b0};
      2'b10:   return {o[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [63:0] extract(input logic [2:0] t, input logic [63:0] d);
    case (t)
      3'b000:  return {{56{d[7]}},  d[7:0]};
      3'b001:  return {{48{d[15]}}, d[15:0]};
      3'b010:  return {{32{d[31]}}, d[31:0]};
      3'b100:  return {56'd0, d[7:0]};
      3'b101:  return {48'd0, d[15:0]};
      3'b110:  return {32'd0, d[31:0]};
      default: return d;
    endcase
  endfunction

  always_comb begin
    req  = memreadM | memwriteM;
    eoff = eff_off(RW_typeM, addrM[2:0]);
    case (RW_typeM[1:0])
      2'b00:   be_base = 8'h01;
      2'b01:   be_base = 8'h03;
      2'b10:   be_base = 8'h0F;
      default: be_base = 8'hFF;
    endcase
    shifted = bus.bus_rdata >> {off_q, 3'b000};
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis;
  always_comb begin
    case (RW_typeM[1:0])
      2'b01:   mis = addrM[0];
      2'b10:   mis = |addrM[1:0];
      2'b11:   mis = |addrM[2:0];
      default: mis = 1'b0;
    endcase
  end
`endif

  // Stall starts combinationally in the request cycle; gated by rst so every
  // output reads 0 while reset is held.
  always_comb begin
    stallM = ~rst & (((state == IDLE) & req) | (state == WAIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 16'd0;
      type_q        <= 3'd0;
      off_q         <= 3'd0;
      load_q        <= 1'b0;
      rdataM        <= 64'd0;
      rvalidM       <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= 8'd0;
      bus.bus_wdata <= 64'd0;
      bus.bus_err   <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalignM     <= 1'b0;
`endif
    end else begin
      rvalidM     <= 1'b0;
      bus.bus_err <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalignM   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req) begin
`ifdef DMEM_MISALIGN_TRAP_EN
            if (mis) begin
              rdataM    <= 64'd0;
              rvalidM   <= 1'b1;
              misalignM <= 1'b1;
              state     <= RESP;
            end else
`endif
            begin
              // Store wins when both requests are present.
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= memwriteM;
              bus.bus_addr  <= {addrM[ADDR_W-1:3], 3'b000};
              bus.bus_be    <= be_base << eoff;
              bus.bus_wdata <= wdataM << {eoff, 3'b000};
              type_q        <= RW_typeM;
              off_q         <= eoff;
              load_q        <= ~memwriteM;
              cnt           <= 16'd0;
              state         <= WAIT;
            end
          end
        end
        WAIT: begin
          // Ready is checked first so it beats a same-cycle timeout.
          if (bus.bus_ready) begin
            bus.bus_req <= 1'b0;
            if (load_q) rdataM <= extract(type_q, shifted);
            rvalidM     <= 1'b1;
            state       <= RESP;
          end else if (cnt == LAST) begin
            bus.bus_req <= 1'b0;
            bus.bus_err <= 1'b1;
            if (load_q) rdataM <= 64'd0;
            rvalidM     <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          // RESP: the MEM instruction is still present but must not reissue.
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl
module tb_dmem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        memreadM, memwriteM;
  logic [2:0]  RW_typeM;
  logic [63:0] addrM, wdataM;
  logic [63:0] rdataM;
  logic        rvalidM, stallM;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misalignM;
`endif

  int vectors = 0;
  int miscompares = 0;

  dmem_ctrl_if #(.ADDR_W(64)) bus_if ();

  dmem_ctrl #(.ADDR_W(64), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .memreadM  (memreadM),
    .memwriteM (memwriteM),
    .RW_typeM  (RW_typeM),
    .addrM     (addrM),
    .wdataM    (wdataM),
    .rdataM    (rdataM),
    .rvalidM   (rvalidM),
    .stallM    (stallM),
`ifdef DMEM_MISALIGN_TRAP_EN
    .misalignM (misalignM),
`endif
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request and runs until rvalidM (bounded). ready_at is the
  // 1-based WAIT cycle that sees bus_ready; 0 means never.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] typ,
                           input logic [63:0] a, input logic [63:0] wd,
                           input logic [63:0] rdat, input int ready_at,
                           output int stalls, output int errs, output int waits,
                           output logic [7:0] be, output logic [63:0] ba,
                           output logic [63:0] bwd, output logic we);
    stalls = 0; errs = 0; waits = 0;
    be = 8'd0; ba = 64'd0; bwd = 64'd0; we = 1'b0;
    memreadM = rd; memwriteM = wr; RW_typeM = typ; addrM = a; wdataM = wd;
    bus_if.bus_ready = 1'b0;
    #1;
    for (int c = 0; c < 20 && !rvalidM; c++) begin
      if (stallM) stalls++;
      if (bus_if.bus_req) begin
        waits++;
        be  = bus_if.bus_be;
        ba  = bus_if.bus_addr;
        bwd = bus_if.bus_wdata;
        we  = bus_if.bus_we;
        bus_if.bus_rdata = rdat;
        bus_if.bus_ready = (waits == ready_at);
      end else begin
        bus_if.bus_ready = 1'b0;
      end
      tick();
      if (bus_if.bus_err) errs++;
    end
    bus_if.bus_ready = 1'b0;
    chk("rvalid_seen", rvalidM, 1'b1);
  endtask

  task automatic finish_access();
    memreadM = 1'b0; memwriteM = 1'b0; bus_if.bus_ready = 1'b0;
    tick();
    chk("rvalid_drop", rvalidM, 1'b0);
  endtask

  int          st, er, wt;
  logic [7:0]  be;
  logic [63:0] ba, bwd;
  logic        we;

  initial begin
    rst = 1'b1; memreadM = 1'b0; memwriteM = 1'b0; RW_typeM = 3'd0;
    addrM = 64'd0; wdataM = 64'd0;
    bus_if.bus_rdata = 64'd0; bus_if.bus_ready = 1'b0;
    tick(); tick();
    chk("rst_rdata", rdataM, 64'd0);
    chk("rst_rvalid", rvalidM, 1'b0);
    chk("rst_stall", stallM, 1'b0);
    chk("rst_req", bus_if.bus_req, 1'b0);
    chk("rst_err", bus_if.bus_err, 1'b0);
    chk("rst_be", bus_if.bus_be, 8'd0);
    rst = 1'b0;
    tick();

    // LB 0x1003, ready on first WAIT cycle
    do_access(1'b1, 1'b0, 3'b000, 64'h1003, 64'd0, 64'h00000000_80000000, 1, st, er, wt, be, ba, bwd, we);
    chk("lb_be", be, 8'h08);
    chk("lb_addr", ba, 64'h1000);
    chk("lb_stall", st, 2);
    chk("lb_rdata", rdataM, 64'hFFFFFFFF_FFFFFF80);
    chk("lb_resp_stall", stallM, 1'b0);
    chk("lb_req_drop", bus_if.bus_req, 1'b0);
    finish_access();
    chk("lb_hold", rdataM, 64'hFFFFFFFF_FFFFFF80);

    // LHU 0x2006, ready on 4th WAIT cycle (same cycle as timeout: ready wins)
    do_access(1'b1, 1'b0, 3'b101, 64'h2006, 64'd0, 64'hBEEF0000_00000000, 4, st, er, wt, be, ba, bwd, we);
    chk("lhu_addr", ba, 64'h2000);
    chk("lhu_be", be, 8'hC0);
    chk("lhu_rdata", rdataM, 64'h00000000_0000BEEF);
    chk("lhu_stall", st, 5);
    chk("lhu_noerr", er, 0);
    finish_access();

    // SW 0x3004
    do_access(1'b0, 1'b1, 3'b010, 64'h3004, 64'h12345678, 64'hDEADDEAD_DEADDEAD, 1, st, er, wt, be, ba, bwd, we);
    chk("sw_we", we, 1'b1);
    chk("sw_be", be, 8'hF0);
    chk("sw_wdata", bwd, 64'h12345678_00000000);
    chk("sw_rdata_keep", rdataM, 64'h00000000_0000BEEF);
    finish_access();

    // LW sign-extension
    do_access(1'b1, 1'b0, 3'b010, 64'h5004, 64'd0, 64'h87654321_00000000, 1, st, er, wt, be, ba, bwd, we);
    chk("lw_rdata", rdataM, 64'hFFFFFFFF_87654321);
    finish_access();

    // Both requests: store wins, no load data
    do_access(1'b1, 1'b1, 3'b000, 64'h6001, 64'hAB, 64'hFFFFFFFF_FFFFFFFF, 1, st, er, wt, be, ba, bwd, we);
    chk("both_we", we, 1'b1);
    chk("both_be", be, 8'h02);
    chk("both_wdata", bwd, 64'h0000_0000_0000_AB00);
    chk("both_rdata_keep", rdataM, 64'hFFFFFFFF_87654321);
    finish_access();

    // LD timeout with TIMEOUT=4
    do_access(1'b1, 1'b0, 3'b011, 64'h4000, 64'd0, 64'h1111_1111_1111_1111, 0, st, er, wt, be, ba, bwd, we);
    chk("to_err", er, 1);
    chk("to_waits", wt, 4);
    chk("to_stall", st, 5);
    chk("to_rdata", rdataM, 64'd0);
    finish_access();
    chk("to_err_drop", bus_if.bus_err, 1'b0);

    // Next LD completes normally
    do_access(1'b1, 1'b0, 3'b011, 64'h4008, 64'd0, 64'h01234567_89ABCDEF, 2, st, er, wt, be, ba, bwd, we);
    chk("ld_rdata", rdataM, 64'h01234567_89ABCDEF);
    chk("ld_stall", st, 3);
    chk("ld_noerr", er, 0);
    chk("ld_be", be, 8'hFF);
    finish_access();

`ifdef DMEM_MISALIGN_TRAP_EN
    // LW 0x102 traps: no bus, one stall cycle
    do_access(1'b1, 1'b0, 3'b010, 64'h102, 64'd0, 64'hFFFFFFFF_FFFFFFFF, 1, st, er, wt, be, ba, bwd, we);
    chk("trap_noreq", wt, 0);
    chk("trap_stall", st, 1);
    chk("trap_flag", misalignM, 1'b1);
    chk("trap_rdata", rdataM, 64'd0);
    finish_access();
    chk("trap_flag_drop", misalignM, 1'b0);
`else
    // Misaligned LW 0x5006 is force-aligned to offset 4
    do_access(1'b1, 1'b0, 3'b010, 64'h5006, 64'd0, 64'h87654321_00000000, 1, st, er, wt, be, ba, bwd, we);
    chk("mis_w_be", be, 8'hF0);
    chk("mis_w_rdata", rdataM, 64'hFFFFFFFF_87654321);
    finish_access();
    // Misaligned LH 0x7003 uses offset 2
    do_access(1'b1, 1'b0, 3'b001, 64'h7003, 64'd0, 64'h00000000_80010000, 1, st, er, wt, be, ba, bwd, we);
    chk("mis_h_be", be, 8'h0C);
    chk("mis_h_rdata", rdataM, 64'hFFFFFFFF_FFFF8001);
    finish_access();
`endif

    // Reset asserted during WAIT
    memreadM = 1'b1; RW_typeM = 3'b011; addrM = 64'h9010;
    tick();
    chk("rstw_req", bus_if.bus_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rstw_req0", bus_if.bus_req, 1'b0);
    chk("rstw_stall0", stallM, 1'b0);
    chk("rstw_addr0", bus_if.bus_addr, 64'd0);
    chk("rstw_be0", bus_if.bus_be, 8'd0);
    chk("rstw_rdata0", rdataM, 64'd0);
    memreadM = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // SD at 0x8 after reset release
    do_access(1'b0, 1'b1, 3'b011, 64'h8, 64'hFFEEDDCC_BBAA9988, 64'd0, 1, st, er, wt, be, ba, bwd, we);
    chk("sd_be", be, 8'hFF);
    chk("sd_addr", ba, 64'h8);
    chk("sd_wdata", bwd, 64'hFFEEDDCC_BBAA9988);
    chk("sd_stall", st, 2);
    finish_access();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
